// File: rtl/user_pkg.sv
// Shared constants and types for the user-domain OBI manager arbiter.
package user_pkg;

    // Index width for a set of num items; one bit minimum so single-entry sets still index.
    function automatic int unsigned idx_width(input int unsigned num);
        return (num > 1) ? int'($clog2(num)) : 1;
    endfunction

    localparam int unsigned NumUserMgr      = 2;
    localparam int unsigned UserArbMaxTrans = 2;

    typedef logic [idx_width(NumUserMgr)-1:0] user_mgr_idx_t;

endpackage

// File: rtl/user_obi_route_fifo.sv
// In-order route FIFO: remembers which requester owns each outstanding downstream transaction.
module user_obi_route_fifo
    import user_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] head_o,
    output logic            empty_o,
    output logic            full_o,
    output logic [CntW-1:0] count_o
);

    localparam int unsigned PtrW = idx_width(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  count_q;
    logic             wr_en, rd_en;

    // Explicit wrap so non-power-of-2 depths never index past the last entry.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign head_o  = mem_q[rptr_q];
    assign rd_en   = pop_i & ~empty_o;
    assign wr_en   = push_i & (~full_o | rd_en);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem_q[wptr_q] <= data_i;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (rd_en) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            unique case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/user_obi_mgr_arb.sv
// Round-robin arbiter sharing the user-domain OBI manager port among NumReq requesters,
// with in-order response routing back to the originating requester.
module user_obi_mgr_arb
    import user_pkg::*;
#(
    parameter int unsigned NumReq    = NumUserMgr,
    parameter int unsigned MaxTrans  = UserArbMaxTrans,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumReq-1:0]           req_i,
    output logic [NumReq-1:0]           gnt_o,
    input  logic [NumReq*AddrWidth-1:0] addr_i,
    input  logic [NumReq-1:0]           we_i,
    input  logic [NumReq*DataWidth/8-1:0] be_i,
    input  logic [NumReq*DataWidth-1:0] wdata_i,
    output logic [NumReq-1:0]           rvalid_o,
    output logic [DataWidth-1:0]        rdata_o,
    output logic                        err_o,
    output logic                        mgr_req_o,
    input  logic                        mgr_gnt_i,
    output logic [AddrWidth-1:0]        mgr_addr_o,
    output logic                        mgr_we_o,
    output logic [DataWidth/8-1:0]      mgr_be_o,
    output logic [DataWidth-1:0]        mgr_wdata_o,
    input  logic                        mgr_rvalid_i,
    input  logic [DataWidth-1:0]        mgr_rdata_i,
    input  logic                        mgr_err_i,
    output logic                        unexp_rsp_o
);

    localparam int unsigned IdxW = idx_width(NumReq);
    localparam int unsigned CntW = $clog2(MaxTrans + 1);
    localparam int unsigned BeW  = DataWidth / 8;

    logic [IdxW-1:0] rr_q, lock_idx_q, rr_sel, sel, rr_next;
    logic            lock_q, found, cap_ok, hs, pop;
    logic [IdxW-1:0] fifo_head;
    logic            fifo_empty, fifo_full;
    logic [CntW-1:0] fifo_count;
    int unsigned     cand;

    // Round-robin search starting at the pointer, wrapping modulo NumReq.
    always_comb begin
        rr_sel = rr_q;
        found  = 1'b0;
        cand   = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = (32'(rr_q) + i) % NumReq;
            if (!found && req_i[IdxW'(cand)]) begin
                rr_sel = IdxW'(cand);
                found  = 1'b1;
            end
        end
    end

    assign sel     = lock_q ? lock_idx_q : rr_sel;
    assign rr_next = (sel == IdxW'(NumReq - 1)) ? '0 : sel + 1'b1;

    assign cap_ok      = (fifo_count < CntW'(MaxTrans));
    assign mgr_req_o   = cap_ok & req_i[sel];
    assign hs          = mgr_req_o & mgr_gnt_i;
    assign mgr_addr_o  = addr_i[sel*AddrWidth +: AddrWidth];
    assign mgr_we_o    = we_i[sel];
    assign mgr_be_o    = be_i[sel*BeW +: BeW];
    assign mgr_wdata_o = wdata_i[sel*DataWidth +: DataWidth];

    assign pop         = mgr_rvalid_i & ~fifo_empty;
    assign unexp_rsp_o = mgr_rvalid_i & fifo_empty;
    assign rdata_o     = mgr_rdata_i;
    assign err_o       = mgr_err_i;

    always_comb begin
        gnt_o                = '0;
        gnt_o[sel]           = hs;
        rvalid_o             = '0;
        rvalid_o[fifo_head]  = pop;
    end

    // A pending-but-ungranted request freezes selection until its handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (hs) begin
            rr_q   <= rr_next;
            lock_q <= 1'b0;
        end else if (mgr_req_o) begin
            lock_q     <= 1'b1;
            lock_idx_q <= sel;
        end
    end

    user_obi_route_fifo #(
        .Depth (MaxTrans),
        .Width (IdxW)
    ) u_route_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (hs),
        .pop_i   (pop),
        .data_i  (sel),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    // Response in the same cycle as its own grant is not supported.
    a_no_same_cycle_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
        !(mgr_rvalid_i && fifo_empty && hs));
    a_req_stable_locked: assert property (@(posedge clk_i) disable iff (rst_i)
        lock_q |-> req_i[lock_idx_q]);
    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(hs && fifo_full && !pop));

endmodule
